// File: rtl/seq_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_pkg
//  Description : Shared types and helpers for the iterative signed divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_div_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter able to hold the values 0..width inclusive
    function automatic int iter_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Magnitude of a sign-extended operand; |MIN| stays representable as unsigned
    function automatic logic [63:0] abs_u(input logic signed [63:0] x);
        return x[63] ? 64'(-x) : 64'(x);
    endfunction

endpackage : seq_div_pkg
`default_nettype wire

// File: rtl/div_clz.sv
`default_nettype none
// ============================================================================
//  Module      : div_clz
//  Description : Leading-zero counter (priority encoder); all-zero input
//                returns WIDTH. Used only when DIV_EARLY_TERM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_clz
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = iter_width(WIDTH)
) (
    input  logic [WIDTH-1:0] x,
    output logic [CNT_W-1:0] cnt
);

    // Later (higher) set bits override earlier ones, so the MSB-most one wins
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) begin
                cnt = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule : div_clz
`default_nettype wire

// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_signed_divider
//  Description : Radix-2 restoring signed divider, one quotient bit per clock,
//                valid/ready on both sides, divide-by-zero and overflow flags.
//                Define DIV_EARLY_TERM_EN to skip leading zeros of |a|.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_signed_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int             c_ITER_W = iter_width(WIDTH);
    localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                r_state;
    logic [WIDTH-1:0]      r_dvd;
    logic [WIDTH-1:0]      r_dvs;
    logic [WIDTH-1:0]      r_rem;
    logic [c_ITER_W-1:0]   r_cnt;
    logic                  r_qneg;
    logic                  r_rneg;
    logic                  r_dz;
    logic                  r_ov;

    logic [WIDTH-1:0]      w_mag_a;
    logic [WIDTH-1:0]      w_mag_b;
    logic                  w_bzero;
    logic                  w_ovf;
    logic [WIDTH-1:0]      w_dvd_init;
    logic [c_ITER_W-1:0]   w_niter;
    logic [WIDTH:0]        w_rem_sh;
    logic [WIDTH-1:0]      w_diff;
    logic                  w_qbit;

    assign w_mag_a = WIDTH'(abs_u(64'(signed'(a))));
    assign w_mag_b = WIDTH'(abs_u(64'(signed'(b))));
    assign w_bzero = (b == '0);
    assign w_ovf   = (a == c_MIN) && (b == '1);

`ifdef DIV_EARLY_TERM_EN
    logic [c_ITER_W-1:0] w_clz;

    div_clz #(
        .WIDTH (WIDTH),
        .CNT_W (c_ITER_W)
    ) u_clz (
        .x   (w_mag_a),
        .cnt (w_clz)
    );

    // Leading zeros of |a| cannot produce quotient bits, so skip them; a=0 still runs once
    assign w_dvd_init = w_mag_a << w_clz;
    assign w_niter    = (w_clz == c_ITER_W'(WIDTH)) ? c_ITER_W'(1)
                                                    : c_ITER_W'(WIDTH) - w_clz;
`else
    assign w_dvd_init = w_mag_a;
    assign w_niter    = c_ITER_W'(WIDTH);
`endif

    // Partial remainder stays below the divisor, so the difference fits in WIDTH bits
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    assign w_qbit   = (w_rem_sh >= {1'b0, r_dvs});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_dvs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        r_qneg   <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_rneg   <= a[WIDTH-1];
                        r_dvs    <= w_mag_b;
                        r_dvd    <= w_dvd_init;
                        // Divide-by-zero reports r=a, so park |a| where the remainder lives
                        r_rem    <= w_bzero ? w_mag_a : '0;
                        r_cnt    <= w_niter - c_ITER_W'(1);
                        r_dz     <= w_bzero;
                        r_ov     <= w_ovf;
                        r_state  <= (w_bzero || w_ovf) ? DONE : CALC;
                    end
                end
                CALC: begin
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_rem <= w_qbit ? w_diff : w_rem_sh[WIDTH-1:0];
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - c_ITER_W'(1);
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid   <= 1'b1;
                        div_by_zero <= r_dz;
                        overflow    <= r_ov;
                        if (r_dz) begin
                            q <= '1;
                        end else if (r_ov) begin
                            q <= c_MIN;
                        end else begin
                            q <= r_qneg ? -r_dvd : r_dvd;
                        end
                        if (r_ov) begin
                            r <= '0;
                        end else begin
                            r <= r_rneg ? -r_rem : r_rem;
                        end
                    end else if (out_ready) begin
                        out_valid   <= 1'b0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        in_ready    <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule : seq_signed_divider
`default_nettype wire
